// File: rtl/seg_scan_pkg.sv
// Shared encodings and the hex-to-segment table for the seven-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  // Decoder enables ordered {G1, G2AN, G2BN}
  localparam logic [2:0] G_ON      = 3'b100;
  localparam logic [2:0] G_OFF     = 3'b011;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  assign seg_n = hex_to_seg(hex);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller driving a 3-8 decoder, with blanking
// gaps between digits and a one-entry write buffer applied at frame boundaries.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16,
  parameter int DIGITS    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  input  logic [7:0]  dig_mask,
  output logic        sel_a,
  output logic        sel_b,
  output logic        sel_c,
  output logic        dec_g1,
  output logic        dec_g2an,
  output logic        dec_g2bn,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int             CW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  SLOT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [2:0]     IDX_LAST   = 3'(DIGITS - 1);

  state_t        state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [2:0]    idx, nxt_idx;
  logic [2:0]    g_q, nxt_g;
  logic [2:0]    sel_q, nxt_sel;
  logic [6:0]    seg_q, nxt_seg;
  logic          dp_q, nxt_dp;
  logic          tick_q, nxt_tick;

  logic [31:0]   act_data, pend_data;
  logic [7:0]    act_dp, pend_dp;
  logic          rdy_q;
  logic          accept, copy;
  logic [6:0]    dec_seg;

  hex7seg u_hex (
    .hex   (act_data[{nxt_idx, 2'b00} +: 4]),
    .seg_n (dec_seg)
  );

  assign accept = wr_valid && rdy_q;
  // Pending data lands on the last-digit DRIVE->BLANK edge, or any time the scan is idle
  assign copy   = !rdy_q && ((state == ST_IDLE) ||
                  (state == ST_DRIVE && cnt == SLOT_LAST && idx == IDX_LAST));

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = idx;
    nxt_g     = G_OFF;
    nxt_sel   = sel_q;
    nxt_seg   = SEG_BLANK;
    nxt_dp    = 1'b1;
    nxt_tick  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          nxt_state = ST_BLANK;
          nxt_cnt   = '0;
          nxt_idx   = '0;
        end
      end
      ST_BLANK: begin
        if (cnt == BLANK_LAST) nxt_state = ST_DRIVE;
        nxt_cnt = cnt + CW'(1);
      end
      ST_DRIVE: begin
        if (cnt == SLOT_LAST) begin
          nxt_state = ST_BLANK;
          nxt_cnt   = '0;
          nxt_idx   = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
    if (!en) begin
      nxt_state = ST_IDLE;
      nxt_cnt   = '0;
    end
    // Outputs are precomputed from the next state so they register on the same edge
    if (nxt_state == ST_BLANK) begin
      nxt_sel = nxt_idx;
    end else if (nxt_state == ST_DRIVE) begin
      nxt_sel  = nxt_idx;
      nxt_g    = dig_mask[nxt_idx] ? G_OFF : G_ON;
      nxt_seg  = dec_seg;
      nxt_dp   = ~act_dp[nxt_idx];
      nxt_tick = (nxt_cnt == SLOT_LAST) && (nxt_idx == IDX_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      idx    <= '0;
      g_q    <= G_OFF;
      sel_q  <= '0;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      idx    <= nxt_idx;
      g_q    <= nxt_g;
      sel_q  <= nxt_sel;
      seg_q  <= nxt_seg;
      dp_q   <= nxt_dp;
      tick_q <= nxt_tick;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q     <= 1'b1;
      pend_data <= '0;
      pend_dp   <= '0;
      act_data  <= '0;
      act_dp    <= '0;
    end else begin
      if (accept) begin
        rdy_q     <= 1'b0;
        pend_data <= wr_data;
        pend_dp   <= wr_dp;
      end else if (copy) begin
        rdy_q    <= 1'b1;
        act_data <= pend_data;
        act_dp   <= pend_dp;
      end
    end
  end

  assign wr_ready   = rdy_q;
  assign {sel_c, sel_b, sel_a}        = sel_q;
  assign {dec_g1, dec_g2an, dec_g2bn} = g_q;
  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a short scan slot (8 cycles, 2 blank).
module tb_seg_scan_ctrl;

  localparam logic [2:0] GON  = 3'b100;
  localparam logic [2:0] GOFF = 3'b011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic [7:0]  wr_dp = '0;
  logic [7:0]  dig_mask = '0;
  logic        sel_a, sel_b, sel_c;
  logic        dec_g1, dec_g2an, dec_g2bn;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;
  logic [6:0] tbl [16];

  seg_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2), .DIGITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .dig_mask   (dig_mask),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .sel_c      (sel_c),
    .dec_g1     (dec_g1),
    .dec_g2an   (dec_g2an),
    .dec_g2bn   (dec_g2bn),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [2:0] s);
    chk({tag, "_g"},    {29'd0, dec_g1, dec_g2an, dec_g2bn}, {29'd0, GOFF});
    chk({tag, "_sel"},  {29'd0, sel_c, sel_b, sel_a}, {29'd0, s});
    chk({tag, "_seg"},  {25'd0, seg_n}, 32'h7F);
    chk({tag, "_dp"},   {31'd0, dp_n}, 32'd1);
    chk({tag, "_tick"}, {31'd0, frame_tick}, 32'd0);
  endtask

  // One full 8-cycle slot: 2 blank cycles then 6 drive cycles
  task automatic run_slot(input logic [2:0] s, input logic [6:0] sg, input logic dpn,
                          input logic [2:0] gd, input logic rdy);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_valid = 1'b0;
      chk($sformatf("s%0d_c%0d_g", s, i), {29'd0, dec_g1, dec_g2an, dec_g2bn},
          {29'd0, (i < 2) ? GOFF : gd});
      chk($sformatf("s%0d_c%0d_sel", s, i), {29'd0, sel_c, sel_b, sel_a}, {29'd0, s});
      chk($sformatf("s%0d_c%0d_seg", s, i), {25'd0, seg_n}, {25'd0, (i < 2) ? 7'h7F : sg});
      chk($sformatf("s%0d_c%0d_dp", s, i), {31'd0, dp_n}, {31'd0, (i < 2) ? 1'b1 : dpn});
      chk($sformatf("s%0d_c%0d_tick", s, i), {31'd0, frame_tick},
          {31'd0, (i == 7 && s == 3'd7)});
      chk($sformatf("s%0d_c%0d_rdy", s, i), {31'd0, wr_ready}, {31'd0, rdy});
    end
  endtask

  initial begin
    tbl[0] = 7'h40; tbl[1] = 7'h79; tbl[2] = 7'h24; tbl[3] = 7'h30;
    tbl[4] = 7'h19; tbl[5] = 7'h12; tbl[6] = 7'h02; tbl[7] = 7'h78;
    tbl[8] = 7'h00; tbl[9] = 7'h10; tbl[10] = 7'h08; tbl[11] = 7'h03;
    tbl[12] = 7'h46; tbl[13] = 7'h21; tbl[14] = 7'h06; tbl[15] = 7'h0E;

    // Reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk_idle("rst0", 3'd0);
    chk("rst0_rdy", {31'd0, wr_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Write while idle: accepted, then copied straight to active
    wr_valid = 1'b1; wr_data = 32'h76543210; wr_dp = 8'h01;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("idle_wr_busy", {31'd0, wr_ready}, 32'd0);
    chk_idle("idle_hold", 3'd0);
    @(negedge clk);
    chk("idle_wr_done", {31'd0, wr_ready}, 32'd1);
    en = 1'b1;

    // Frame 1
    for (int k = 0; k < 8; k++)
      run_slot(3'(k), tbl[k], (k == 0) ? 1'b0 : 1'b1, GON, 1'b1);

    // Frame 2 with a mid-frame write that must wait for the boundary
    for (int k = 0; k < 3; k++)
      run_slot(3'(k), tbl[k], (k == 0) ? 1'b0 : 1'b1, GON, 1'b1);
    wr_valid = 1'b1; wr_data = 32'hFFFFFFFF; wr_dp = 8'h00;
    for (int k = 3; k < 8; k++)
      run_slot(3'(k), tbl[k], 1'b1, GON, 1'b0);

    // Frame 3: new data, digit 2 masked dark
    dig_mask = 8'h04;
    for (int k = 0; k < 8; k++)
      run_slot(3'(k), 7'h0E, 1'b1, (k == 2) ? GOFF : GON, 1'b1);
    dig_mask = 8'h00;

    // Frame 4: drop en mid-DRIVE of digit 5
    for (int k = 0; k < 5; k++)
      run_slot(3'(k), 7'h0E, 1'b1, GON, 1'b1);
    repeat (4) @(negedge clk);
    chk("d5_drive_g", {29'd0, dec_g1, dec_g2an, dec_g2bn}, {29'd0, GON});
    chk("d5_drive_sel", {29'd0, sel_c, sel_b, sel_a}, 32'd5);
    en = 1'b0;
    @(negedge clk);
    chk_idle("en_off1", 3'd5);
    @(negedge clk);
    chk_idle("en_off2", 3'd5);
    en = 1'b1;
    run_slot(3'd0, 7'h0E, 1'b1, GON, 1'b1);

    // Async reset mid-DRIVE of digit 1 with a write pending
    wr_valid = 1'b1; wr_data = 32'h12345678; wr_dp = 8'hFF;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pend_busy", {31'd0, wr_ready}, 32'd0);
    chk("pend_drive_g", {29'd0, dec_g1, dec_g2an, dec_g2bn}, {29'd0, GON});
    #2 rst = 1'b1;
    #1;
    chk_idle("rst_mid", 3'd0);
    chk("rst_mid_rdy", {31'd0, wr_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_slot(3'd0, 7'h40, 1'b1, GON, 1'b1);
    run_slot(3'd1, 7'h40, 1'b1, GON, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
